// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory DMA engine.
// This package holds the FSM state encodings and the transfer mode constants.
package mem_dma_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_READ   = 2'd1;
    localparam state_t ST_WRITE  = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma.sv
// Single-channel memory DMA: copies src->dst or fills dst with a constant,
// one entry per READ/WRITE pair, against a memory with same-cycle read data.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned A = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [A-1:0] src_addr,
    input  logic [A-1:0] dst_addr,
    input  logic [A-1:0] len,
    input  logic [W-1:0] fill_value,
    output logic         busy,
    output logic         done,
    output logic [A-1:0] mem_addr,
    output logic         mem_read_en,
    output logic         mem_write_en,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata
);

    state_t       state, state_n;
    logic [A-1:0] src_ptr, src_n;
    logic [A-1:0] dst_ptr, dst_n;
    logic [A-1:0] remaining, rem_n;
    logic         mode_q, mode_n;
    logic [W-1:0] fill_q, fill_n;
    logic [W-1:0] data_buf, buf_n;

    logic         busy_n, done_n, rd_n, wr_n;
    logic [A-1:0] addr_n;
    logic [W-1:0] wdata_n;

    // Next-state and datapath updates
    always_comb begin
        state_n = state;
        src_n   = src_ptr;
        dst_n   = dst_ptr;
        rem_n   = remaining;
        mode_n  = mode_q;
        fill_n  = fill_q;
        buf_n   = data_buf;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    src_n  = src_addr;
                    dst_n  = dst_addr;
                    rem_n  = len;
                    mode_n = mode;
                    fill_n = fill_value;
                    if (len == A'(0))
                        state_n = ST_FINISH;
                    else if (mode == MODE_FILL)
                        state_n = ST_WRITE;
                    else
                        state_n = ST_READ;
                end
            end
            ST_READ: begin
                buf_n   = mem_rdata;
                state_n = ST_WRITE;
            end
            ST_WRITE: begin
                src_n = src_ptr + A'(1);
                dst_n = dst_ptr + A'(1);
                rem_n = remaining - A'(1);
                if (remaining == A'(1))
                    state_n = ST_FINISH;
                else if (mode_q == MODE_FILL)
                    state_n = ST_WRITE;
                else
                    state_n = ST_READ;
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered copies
    // line up with the state they describe.
    always_comb begin
        busy_n  = 1'b0;
        done_n  = 1'b0;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;
        case (state_n)
            ST_READ: begin
                busy_n = 1'b1;
                rd_n   = 1'b1;
                addr_n = src_n;
            end
            ST_WRITE: begin
                busy_n  = 1'b1;
                wr_n    = 1'b1;
                addr_n  = dst_n;
                wdata_n = (mode_n == MODE_FILL) ? fill_n : buf_n;
            end
            ST_FINISH: begin
                busy_n = 1'b1;
                done_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            remaining    <= '0;
            mode_q       <= MODE_COPY;
            fill_q       <= '0;
            data_buf     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state        <= state_n;
            src_ptr      <= src_n;
            dst_ptr      <= dst_n;
            remaining    <= rem_n;
            mode_q       <= mode_n;
            fill_q       <= fill_n;
            data_buf     <= buf_n;
            busy         <= busy_n;
            done         <= done_n;
            mem_read_en  <= rd_n;
            mem_write_en <= wr_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Randomized self-checking bench for mem_dma: a per-cycle expected-access queue
// plus a model memory, checked on every falling edge against the DUT outputs.
module tb_mem_dma;

    localparam int unsigned N = 256;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd;
        logic       we;
        logic       use_src;
        logic [7:0] addr;
        logic [7:0] src;
        logic [7:0] data;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] src_addr = 8'h00;
    logic [7:0] dst_addr = 8'h00;
    logic [7:0] len = 8'h00;
    logic [7:0] fill_value = 8'h00;
    logic       busy, done, mem_read_en, mem_write_en;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [N];
    logic [7:0] img [N];
    logic [7:0] model_mem [N];
    logic       load = 1'b0;

    rec_t q[$];
    bit   model_idle = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   last_done_cyc = 0;
    logic prev_done = 1'b0;

    mem_dma #(.W(8), .A(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, write on the rising edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= img[i];
        end else if (mem_write_en) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected bus activity for one accepted transfer, one record per cycle
    function automatic void push_xfer(bit m, logic [7:0] s, logic [7:0] d, logic [7:0] l, logic [7:0] f);
        rec_t r;
        for (int i = 0; i < int'(l); i++) begin
            if (m == 1'b0) begin
                r = '0; r.busy = 1'b1; r.rd = 1'b1; r.addr = s + 8'(i);
                q.push_back(r);
            end
            r = '0; r.busy = 1'b1; r.we = 1'b1; r.addr = d + 8'(i);
            if (m == 1'b0) begin
                r.use_src = 1'b1; r.src = s + 8'(i);
            end else begin
                r.data = f;
            end
            q.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1;
        q.push_back(r);
    endfunction

    always @(negedge clk) begin
        rec_t       r;
        logic [7:0] ew;
        if (load) for (int i = 0; i < N; i++) model_mem[i] = img[i];
        if (reset) begin
            q.delete();
            model_idle = 1'b1;
            prev_done  = 1'b0;
            chk("reset_busy", busy, 0);
            chk("reset_done", done, 0);
            chk("reset_rd", mem_read_en, 0);
            chk("reset_we", mem_write_en, 0);
            chk("reset_addr", mem_addr, 0);
            chk("reset_wdata", mem_wdata, 0);
        end else begin
            if (q.size() > 0) begin
                r = q.pop_front();
                model_idle = 1'b0;
            end else begin
                r = '0;
                model_idle = 1'b1;
            end
            ew = r.we ? (r.use_src ? model_mem[r.src] : r.data) : 8'h00;
            chk("busy", busy, r.busy);
            chk("done", done, r.done);
            chk("mem_read_en", mem_read_en, r.rd);
            chk("mem_write_en", mem_write_en, r.we);
            chk("mem_addr", mem_addr, r.addr);
            chk("mem_wdata", mem_wdata, ew);
            chk("rd_we_exclusive", mem_read_en & mem_write_en, 0);
            chk("done_one_cycle", prev_done & done, 0);
            if (r.we) model_mem[r.addr] = ew;
            if (done) begin
                done_count++;
                last_done_cyc = cyc;
            end
            prev_done = done;
        end
    end

    task automatic do_start(input bit m, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input logic [7:0] f,
                            output bit acc, output int acc_cyc);
        @(posedge clk);
        #1;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_value = f;
        @(posedge clk);
        acc = model_idle;
        if (acc) push_xfer(m, s, d, l, f);
        #1;
        acc_cyc    = cyc;
        start      = 1'b0;
        mode       = 1'($urandom);
        src_addr   = 8'($urandom);
        dst_addr   = 8'($urandom);
        len        = 8'($urandom);
        fill_value = 8'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 1, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit         acc;
        int         ac;
        int         dc;
        logic [7:0] lr;

        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        img[8'h10] = 8'hA1; img[8'h11] = 8'hB2; img[8'h12] = 8'hC3; img[8'h13] = 8'hD4;
        for (int i = 8'h80; i < 8'h84; i++) img[i] = 8'hEE;

        load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load  = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Copy of four entries
        do_start(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, acc, ac);
        wait_idle();
        chk("copy_latency", last_done_cyc - ac + 1, 9);
        chk("copy_m40", mem[8'h40], 8'hA1);
        chk("copy_m41", mem[8'h41], 8'hB2);
        chk("copy_m42", mem[8'h42], 8'hC3);
        chk("copy_m43", mem[8'h43], 8'hD4);

        // Fill across the top of the address space
        do_start(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, acc, ac);
        wait_idle();
        chk("fill_latency", last_done_cyc - ac + 1, 4);
        chk("fill_mFE", mem[8'hFE], 8'h5A);
        chk("fill_mFF", mem[8'hFF], 8'h5A);
        chk("fill_m00", mem[8'h00], 8'h5A);

        // Zero length
        do_start(1'b0, 8'h20, 8'h30, 8'd0, 8'h00, acc, ac);
        wait_idle();
        chk("zero_latency", last_done_cyc - ac + 1, 1);

        // Start while busy is ignored
        dc = done_count;
        do_start(1'b0, 8'h10, 8'h60, 8'd2, 8'h00, acc, ac);
        do_start(1'b1, 8'h00, 8'h61, 8'd5, 8'h77, acc, ac);
        wait_idle();
        chk("busy_m60", mem[8'h60], 8'hA1);
        chk("busy_m61", mem[8'h61], 8'hB2);
        chk("busy_m62", mem[8'h62], model_mem[8'h62]);
        chk("busy_done_count", done_count - dc, 1);

        // Reset during the second write of a copy
        do_start(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, acc, ac);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_write_we", mem_write_en, 1);
        chk("rst_in_write_addr", mem_addr, 8'h81);
        dc = done_count;
        reset = 1'b1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_we", mem_write_en, 0);
        chk("rst_async_addr", mem_addr, 0);
        chk("rst_async_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        chk("rst_m80", mem[8'h80], 8'hA1);
        chk("rst_m81", mem[8'h81], 8'hEE);
        chk("rst_no_done", done_count - dc, 0);
        do_start(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, acc, ac);
        wait_idle();
        chk("rst_restart_m83", mem[8'h83], 8'hD4);
        chk("rst_restart_done", done_count - dc, 1);

        // Randomized transfers with occasional start pulses while busy
        for (int t = 0; t < 40; t++) begin
            lr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(1, 16));
            do_start(1'($urandom), 8'($urandom), 8'($urandom), lr, 8'($urandom), acc, ac);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_start(1'($urandom), 8'($urandom), 8'($urandom),
                         8'($urandom_range(0, 8)), 8'($urandom), acc, ac);
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        for (int i = 0; i < N; i++) chk($sformatf("final_mem_%0h", i), mem[i], model_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
